// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multi-cycle control unit.
//   - opcode constants for the supported MIPS subset
//   - FSM state enum
//   - ALUop / ALUSrcB / PCSrc / trap_cause encodings
//   - op_dec_t: one-hot opcode decode plus legal flag
package ctrl_pkg;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_MEM_ADDR,
    S_MEM_RD, S_MEM_WR, S_WB_MEM, S_BRANCH, S_JUMP, S_TRAP
  } state_t;

  // ALUop encoding shared with the single-cycle ALU control.
  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_RTYPE = 3'b001;
  localparam logic [2:0] ALUOP_OR    = 3'b010;
  localparam logic [2:0] ALUOP_SUB   = 3'b100;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_BUS     = 2'b10;

  typedef struct packed {
    logic r;
    logic ori;
    logic addiu;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic legal;
  } op_dec_t;

endpackage

// File: rtl/op_decoder.sv
// op_decoder: combinational one-hot decode of the 6-bit opcode.
//   op  in  6       opcode from the instruction register
//   dec out struct  one-hot opcode flags plus a legal flag
module op_decoder
  import ctrl_pkg::*;
(
  input  logic [5:0] op,
  output op_dec_t    dec
);

  always_comb begin
    dec       = '0;
    dec.r     = (op == OP_R);
    dec.ori   = (op == OP_ORI);
    dec.addiu = (op == OP_ADDIU);
    dec.lw    = (op == OP_LW);
    dec.sw    = (op == OP_SW);
    dec.beq   = (op == OP_BEQ);
    dec.j     = (op == OP_J);
    dec.legal = dec.r | dec.ori | dec.addiu | dec.lw | dec.sw | dec.beq | dec.j;
  end

endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle control FSM for the MIPS-subset datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB steps, waits on mem_ready with a
// bounded timeout, traps on illegal opcodes or bus timeouts (sticky until
// rst) and counts retired instructions.
//   clk, rst          clock, synchronous active-high reset
//   OP, mem_ready     opcode and memory-completion inputs
//   PCWr..ExtOp       single-bit datapath controls
//   ALUSrcB, PCSrc,
//   ALUop             multi-bit datapath selects
//   R_type            combinational OP==R
//   instr_done        pulse on each instruction's final cycle
//   trap, trap_cause  halt flag and reason
//   icount            retired-instruction counter (wraps)
module mc_control_unit
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       OP,
  input  logic             mem_ready,
  output logic             PCWr,
  output logic             PCWrCond,
  output logic             IorD,
  output logic             IRWr,
  output logic             MemRd,
  output logic             MemWr,
  output logic             MemtoReg,
  output logic             RegWr,
  output logic             RegDst,
  output logic             ALUSrcA,
  output logic             ExtOp,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSrc,
  output logic [2:0]       ALUop,
  output logic             R_type,
  output logic             instr_done,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] icount
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  // The wait cycle that would bring the count to MEM_TIMEOUT.
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  op_dec_t dec;

  op_decoder u_op_decoder (
    .op  (OP),
    .dec (dec)
  );

  assign R_type = dec.r;

  state_t            state_reg, state_next;
  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic [1:0]        cause_reg, cause_next;
  logic [CNT_W-1:0]  icount_reg;
  logic              stall;

  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    cause_next = cause_reg;
    stall      = 1'b0;
    case (state_reg)
      S_FETCH:    if (mem_ready) state_next = S_DECODE; else stall = 1'b1;
      S_DECODE: begin
        if (!dec.legal) begin
          state_next = S_TRAP;
          cause_next = CAUSE_ILLEGAL;
        end else if (dec.r)            state_next = S_EXEC_R;
        else if (dec.ori | dec.addiu)  state_next = S_EXEC_I;
        else if (dec.lw | dec.sw)      state_next = S_MEM_ADDR;
        else if (dec.beq)              state_next = S_BRANCH;
        else                           state_next = S_JUMP;
      end
      S_EXEC_R:   state_next = S_WB_R;
      S_EXEC_I:   state_next = S_WB_I;
      S_MEM_ADDR: state_next = dec.sw ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) state_next = S_WB_MEM; else stall = 1'b1;
      S_MEM_WR:   if (mem_ready) state_next = S_FETCH; else stall = 1'b1;
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: state_next = S_FETCH;
      S_TRAP:     state_next = S_TRAP;
      default:    state_next = S_FETCH;
    endcase

    // A ready in the timeout cycle takes the non-stall branch above, so it wins.
    if (stall) begin
      if ((MEM_TIMEOUT > 0) && (wait_reg == WAIT_LAST)) begin
        state_next = S_TRAP;
        cause_next = CAUSE_BUS;
      end else begin
        wait_next = wait_reg + 1'b1;
      end
    end

    // Only the wait states use the counter, so clearing on every state
    // change is the same as clearing on entry to FETCH/MEM_RD/MEM_WR.
    if (state_next != state_reg) wait_next = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_FETCH;
      wait_reg   <= '0;
      cause_reg  <= CAUSE_NONE;
      icount_reg <= '0;
    end else begin
      state_reg  <= state_next;
      wait_reg   <= wait_next;
      cause_reg  <= cause_next;
      if (instr_done) icount_reg <= icount_reg + 1'b1;
    end
  end

  // Moore decode of the state register; IRWr/PCWr in FETCH and
  // instr_done in MEM_WR are additionally qualified by mem_ready.
  always_comb begin
    PCWr       = 1'b0;
    PCWrCond   = 1'b0;
    IorD       = 1'b0;
    IRWr       = 1'b0;
    MemRd      = 1'b0;
    MemWr      = 1'b0;
    MemtoReg   = 1'b0;
    RegWr      = 1'b0;
    RegDst     = 1'b0;
    ALUSrcA    = 1'b0;
    ExtOp      = 1'b0;
    ALUSrcB    = SRCB_RT;
    PCSrc      = PCSRC_ALU;
    ALUop      = ALUOP_ADD;
    instr_done = 1'b0;
    case (state_reg)
      S_FETCH: begin
        MemRd   = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWr    = mem_ready;
        PCWr    = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMM_SL2;
        ExtOp   = 1'b1;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUop   = ALUOP_RTYPE;
      end
      S_WB_R: begin
        RegWr      = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        if (dec.ori) ALUop = ALUOP_OR;
        else         ExtOp = 1'b1;
      end
      S_WB_I: begin
        RegWr      = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ExtOp   = 1'b1;
      end
      S_MEM_RD: begin
        MemRd = 1'b1;
        IorD  = 1'b1;
      end
      S_WB_MEM: begin
        RegWr      = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        MemWr      = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUop      = ALUOP_SUB;
        PCWrCond   = 1'b1;
        PCSrc      = PCSRC_ALUOUT;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        PCWr       = 1'b1;
        PCSrc      = PCSRC_JUMP;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign trap       = (state_reg == S_TRAP);
  assign trap_cause = cause_reg;
  assign icount     = icount_reg;

endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: scoreboard bench for mc_control_unit.
// Each instruction pushes its expected cycle count, final-cycle controls,
// trap cause and icount; the entry is popped when the DUT finishes or traps.
// A small memory model answers mem_ready with programmable stalls.
module tb_mc_control_unit;
  import ctrl_pkg::*;

  localparam int TO = 3;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic [5:0]    OP;
  logic          mem_ready;
  logic          PCWr, PCWrCond, IorD, IRWr, MemRd, MemWr, MemtoReg;
  logic          RegWr, RegDst, ALUSrcA, ExtOp;
  logic [1:0]    ALUSrcB, PCSrc;
  logic [2:0]    ALUop;
  logic          R_type, instr_done, trap;
  logic [1:0]    trap_cause;
  logic [CW-1:0] icount;

  mc_control_unit #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .OP         (OP),
    .mem_ready  (mem_ready),
    .PCWr       (PCWr),
    .PCWrCond   (PCWrCond),
    .IorD       (IorD),
    .IRWr       (IRWr),
    .MemRd      (MemRd),
    .MemWr      (MemWr),
    .MemtoReg   (MemtoReg),
    .RegWr      (RegWr),
    .RegDst     (RegDst),
    .ALUSrcA    (ALUSrcA),
    .ExtOp      (ExtOp),
    .ALUSrcB    (ALUSrcB),
    .PCSrc      (PCSrc),
    .ALUop      (ALUop),
    .R_type     (R_type),
    .instr_done (instr_done),
    .trap       (trap),
    .trap_cause (trap_cause),
    .icount     (icount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [5:0]    op;
    int            cycles;
    logic [7:0]    fin;   // {RegWr,RegDst,MemtoReg,MemWr,PCWr,PCWrCond,PCSrc}
    logic [1:0]    cause;
    logic [CW-1:0] icnt;
  } exp_t;

  exp_t          sb[$];
  logic [CW-1:0] exp_icount;
  int            fs_left, ds_left;

  // Memory model: fetch and data accesses each stall a programmed number
  // of cycles; outside accesses mem_ready is random (the DUT must ignore it).
  task automatic mem_model();
    if (MemRd && !IorD) begin
      if (fs_left > 0) begin mem_ready = 1'b0; fs_left--; end
      else mem_ready = 1'b1;
    end else if ((MemRd || MemWr) && IorD) begin
      if (ds_left > 0) begin mem_ready = 1'b0; ds_left--; end
      else mem_ready = 1'b1;
    end else begin
      mem_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // Ends at posedge+1 with the DUT in its first FETCH cycle.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'b0;
    OP = 6'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_icount = '0;
  endtask

  task automatic run_instr(input logic [5:0] op, input int fs, input int ds);
    exp_t e;
    int   cyc = 0;
    int   phase = -1;
    bit   done = 1'b0;
    bit   mem_op;
    e.op = op;
    e.cause = CAUSE_NONE;
    e.fin = 8'h00;
    mem_op = (op == OP_LW) || (op == OP_SW);
    case (op)
      OP_R:             begin e.cycles = 4 + fs;      e.fin = 8'b1100_0000; end
      OP_ORI, OP_ADDIU: begin e.cycles = 4 + fs;      e.fin = 8'b1000_0000; end
      OP_LW:            begin e.cycles = 5 + fs + ds; e.fin = 8'b1010_0000; end
      OP_SW:            begin e.cycles = 4 + fs + ds; e.fin = 8'b0001_0000; end
      OP_BEQ:           begin e.cycles = 3 + fs;      e.fin = 8'b0000_0101; end
      OP_J:             begin e.cycles = 3 + fs;      e.fin = 8'b0000_1010; end
      default:          begin e.cycles = 3 + fs;      e.cause = CAUSE_ILLEGAL; end
    endcase
    // fetch, decode, address, TO wait cycles, then the first TRAP cycle
    if (mem_op && ds >= TO) begin
      e.cycles = fs + 3 + TO + 1;
      e.cause = CAUSE_BUS;
    end
    if (e.cause == CAUSE_NONE) exp_icount = exp_icount + 1'b1;
    e.icnt = exp_icount;
    sb.push_back(e);
    fs_left = fs;
    ds_left = ds;

    while (!done && cyc < 60) begin
      @(negedge clk);
      OP = op;
      mem_model();
      #1;
      cyc++;
      if (MemRd && !IorD) begin
        check_eq("fetch_irwr_pcwr", {IRWr, PCWr}, {mem_ready, mem_ready});
        check_eq("fetch_srcb", ALUSrcB, SRCB_FOUR);
        if (mem_ready) phase = 0;
      end else if (phase >= 0) begin
        phase++;
      end
      if (phase == 1)
        check_eq("decode_ctrl", {ALUSrcA, ALUSrcB, ExtOp, ALUop}, 7'b0_11_1_000);
      if (phase == 2) begin
        case (op)
          OP_R:         check_eq("exec_r",   {ALUSrcA, ALUSrcB, ALUop}, 6'b1_00_001);
          OP_ORI:       check_eq("exec_ori", {ALUSrcA, ALUSrcB, ExtOp, ALUop}, 7'b1_10_0_010);
          OP_ADDIU:     check_eq("exec_addiu", {ALUSrcA, ALUSrcB, ExtOp, ALUop}, 7'b1_10_1_000);
          OP_LW, OP_SW: check_eq("mem_addr", {ALUSrcA, ALUSrcB, ExtOp, ALUop}, 7'b1_10_1_000);
          OP_BEQ:       check_eq("branch_alu", {ALUSrcA, ALUSrcB, ALUop}, 6'b1_00_100);
          default: ;
        endcase
      end
      if (instr_done) begin
        check_eq("final_ctrl", {RegWr, RegDst, MemtoReg, MemWr, PCWr, PCWrCond, PCSrc}, sb[0].fin);
        done = 1'b1;
      end else if (trap) begin
        done = 1'b1;
      end
    end

    e = sb.pop_front();
    check_eq("end_seen", {31'd0, done}, 32'd1);
    check_eq("cycles", cyc, e.cycles);
    check_eq("trap_cause", trap_cause, e.cause);
    @(posedge clk);
    #1;
    check_eq("icount", icount, e.icnt);
    $display("op=%02h fs=%0d ds=%0d cycles=%0d cause=%0d icount=%0d",
             op, fs, ds, cyc, trap_cause, icount);
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    mem_ready = 1'b0;
    OP = 6'd0;
    exp_icount = '0;
    fs_left = 0;
    ds_left = 0;

    // Reset state
    do_reset();
    check_eq("rst_ctrl", {MemRd, IorD, ALUSrcB, IRWr, PCWr, instr_done, trap}, 8'b1_0_01_0_0_0_0);
    check_eq("rst_cause", trap_cause, CAUSE_NONE);
    check_eq("rst_icount", icount, 0);

    // lw with 2 fetch stalls and 1 data stall: 8 cycles
    run_instr(OP_LW, 2, 1);

    // Back-to-back mix from reset: 4/4/4/3/3
    do_reset();
    run_instr(OP_R, 0, 0);
    check_eq("r_type", R_type, 1'b1);
    run_instr(OP_ORI, 0, 0);
    run_instr(OP_SW, 0, 0);
    run_instr(OP_BEQ, 0, 0);
    run_instr(OP_J, 0, 0);
    check_eq("icount_five", icount, 5);
    run_instr(OP_ADDIU, 0, 0);
    run_instr(OP_LW, 0, 0);
    // ready arrives in the timeout cycle: completes normally
    run_instr(OP_SW, 0, 2);

    // Reset while waiting in MEM_RD
    found = 1'b0;
    fs_left = 0;
    ds_left = 5;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      OP = OP_LW;
      mem_model();
      #1;
      if (MemRd && IorD) found = 1'b1;
    end
    check_eq("mid_rst_reach", {31'd0, found}, 32'd1);
    rst = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_icount = '0;
    check_eq("mid_rst_ctrl", {MemRd, IorD, trap}, 3'b1_0_0);
    check_eq("mid_rst_icount", icount, 0);
    $display("reset in MEM_RD: icount=%0d MemRd=%0d IorD=%0d", icount, MemRd, IorD);
    run_instr(OP_J, 0, 0);

    // Bus timeout in MEM_WR
    run_instr(OP_SW, 0, 3);
    check_eq("timeout_trap", trap, 1'b1);
    do_reset();

    // Illegal opcode, then 20 cycles halted with all enables low
    run_instr(6'b111111, 0, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      check_eq("trap_hold", {PCWr, PCWrCond, IRWr, MemRd, MemWr, RegWr, instr_done, trap, trap_cause},
               {7'b0000000, 1'b1, CAUSE_ILLEGAL});
    end
    check_eq("trap_icount", icount, exp_icount);

    // Counter wrap: 17 retirements on a 4-bit counter
    do_reset();
    for (int i = 0; i < 17; i++) run_instr(OP_J, 0, 0);
    check_eq("icount_wrap", icount, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
